// File: rtl/gram_bist_pkg.sv
// gram_bist_pkg: shared mode encodings, FSM states and LFSR step for the gram Wishbone BIST.
package gram_bist_pkg;
   localparam logic [1:0] MODE_ADDR     = 2'd0;
   localparam logic [1:0] MODE_LFSR     = 2'd1;
   localparam logic [1:0] MODE_FIXED    = 2'd2;
   localparam logic [1:0] MODE_INV_ADDR = 2'd3;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FINISH} state_t;
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
   endfunction
endpackage

// File: rtl/gram_bist_pattern.sv
// gram_bist_pattern: per-word test pattern generator shared by the write and read passes.
module gram_bist_pattern
   import gram_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 30,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  restart,
   input  logic                  advance,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic [ADDR_WIDTH-1:0] adr,
   output logic [DATA_WIDTH-1:0] word
);
   logic [31:0]           lfsr, seed32, fix32;
   logic [DATA_WIDTH-1:0] fix, rep, adr_w;
   assign seed32 = 32'(seed);
   assign fix32  = 32'(fix);
   assign adr_w  = DATA_WIDTH'(adr);
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= '0;
         fix  <= '0;
      end else if (load) begin
         fix  <= seed;
         lfsr <= seed32 == '0 ? 32'd1 : seed32;
      end else if (restart)
         lfsr <= fix32 == '0 ? 32'd1 : fix32;
      else if (advance)
         lfsr <= lfsr_next(lfsr);
   end
   always_comb begin
      rep = '0;
      for (int i = 0; i < DATA_WIDTH; i++) rep[i] = lfsr[i % 32];
   end
   assign word = mode == MODE_LFSR ? rep :
                 mode == MODE_FIXED ? fix :
                 mode == MODE_INV_ADDR ? ~adr_w : adr_w;
endmodule

// File: rtl/gram_wishbone_bist.sv
// gram_wishbone_bist: Wishbone-master memory self test; writes a pattern, reads it back, counts errors and cycles.
module gram_wishbone_bist
   import gram_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 30,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int CNT_WIDTH  = 32,
   parameter int TIMEOUT    = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_adr,
   input  logic [LEN_WIDTH-1:0]    length,
   input  logic [1:0]              mode,
   input  logic [DATA_WIDTH-1:0]   seed,
   input  logic                    do_write,
   input  logic                    do_read,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout,
   output logic [CNT_WIDTH-1:0]    error_count,
   output logic [ADDR_WIDTH-1:0]   first_err_adr,
   output logic [DATA_WIDTH-1:0]   first_err_dat,
   output logic [CNT_WIDTH-1:0]    cycle_count,
   output logic [ADDR_WIDTH-1:0]   wb_adr,
   output logic [DATA_WIDTH-1:0]   wb_dat_w,
   input  logic [DATA_WIDTH-1:0]   wb_dat_r,
   output logic [DATA_WIDTH/8-1:0] wb_sel,
   output logic                    wb_cyc,
   output logic                    wb_stb,
   output logic                    wb_we,
   input  logic                    wb_ack
);
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   state_t                state;
   logic [ADDR_WIDTH-1:0] adr, base_q;
   logic [LEN_WIDTH-1:0]  len_q, cnt;
   logic [TW-1:0]         tcnt;
   logic [1:0]            mode_q;
   logic                  rd_q, last, is_gap;
   logic [DATA_WIDTH-1:0] word;
   assign last     = cnt == len_q - LEN_WIDTH'(1);
   assign is_gap   = state == WR_GAP || state == RD_GAP;
   assign wb_adr   = adr;
   assign wb_dat_w = word;
   assign wb_sel   = '1;
   gram_bist_pattern #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_pattern (
      .clk     (clk),
      .rst     (rst),
      .load    (state == IDLE && start),
      .restart (state == WR_GAP && last && rd_q),
      .advance (is_gap && !last),
      .mode    (mode_q),
      .seed    (seed),
      .adr     (adr),
      .word    (word)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         timeout       <= 1'b0;
         error_count   <= '0;
         first_err_adr <= '0;
         first_err_dat <= '0;
         cycle_count   <= '0;
         wb_cyc        <= 1'b0;
         wb_stb        <= 1'b0;
         wb_we         <= 1'b0;
         adr           <= '0;
         base_q        <= '0;
         len_q         <= '0;
         cnt           <= '0;
         tcnt          <= '0;
         mode_q        <= MODE_ADDR;
         rd_q          <= 1'b0;
      end else begin
         if (busy) cycle_count <= cycle_count + CNT_WIDTH'(~&cycle_count);
         case (state)
            IDLE: if (start) begin
               base_q        <= base_adr;
               len_q         <= length;
               mode_q        <= mode;
               rd_q          <= do_read;
               adr           <= base_adr;
               cnt           <= '0;
               tcnt          <= '0;
               error_count   <= '0;
               first_err_adr <= '0;
               first_err_dat <= '0;
               cycle_count   <= '0;
               done          <= 1'b0;
               timeout       <= 1'b0;
               busy          <= 1'b1;
               if (length == '0 || !(do_write || do_read))
                  state <= FINISH;
               else begin
                  state  <= do_write ? WR_REQ : RD_REQ;
                  wb_cyc <= 1'b1;
                  wb_stb <= 1'b1;
                  wb_we  <= do_write;
               end
            end
            WR_REQ, RD_REQ: if (wb_ack) begin
               wb_cyc <= 1'b0;
               wb_stb <= 1'b0;
               state  <= state == WR_REQ ? WR_GAP : RD_GAP;
               if (state == RD_REQ && wb_dat_r != word) begin
                  // error_count never wraps back to zero, so zero marks "no mismatch yet"
                  if (error_count == '0) begin
                     first_err_adr <= adr;
                     first_err_dat <= wb_dat_r;
                  end
                  error_count <= error_count + CNT_WIDTH'(~&error_count);
               end
            end else if (TIMEOUT != 0 && tcnt == TW'(TIMEOUT)) begin
               wb_cyc  <= 1'b0;
               wb_stb  <= 1'b0;
               timeout <= 1'b1;
               state   <= FINISH;
            end else
               tcnt <= tcnt + TW'(1);
            WR_GAP, RD_GAP: begin
               tcnt <= '0;
               if (!last) begin
                  cnt    <= cnt + LEN_WIDTH'(1);
                  adr    <= adr + ADDR_WIDTH'(1);
                  wb_cyc <= 1'b1;
                  wb_stb <= 1'b1;
                  state  <= state == WR_GAP ? WR_REQ : RD_REQ;
               end else if (state == WR_GAP && rd_q) begin
                  cnt    <= '0;
                  adr    <= base_q;
                  wb_cyc <= 1'b1;
                  wb_stb <= 1'b1;
                  wb_we  <= 1'b0;
                  state  <= RD_REQ;
               end else
                  state <= FINISH;
            end
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               wb_we <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/gram_wishbone_bist.md
Name: gram_wishbone_bist

Overview:
- Synthesizable Wishbone-master built-in self test for the gram DRAM port; runs in hardware after DFII is switched to hardware control (DFII_CONTROL_SEL).
- Writes a generated pattern over an address window, reads it back, compares each word and counts the cycles taken.
- Sits between a CSR/debug master and the user Wishbone port of the gram top, so on-silicon bring-up can run memory checks and measure throughput.
- Parametrised in data width, address width, pattern mode and bus timeout.

Parameters:
ADDR_WIDTH, 30, Wishbone word-address width
DATA_WIDTH, 32, Wishbone data width, multiple of 8, 8..128
LEN_WIDTH, 16, width of the word-count register
CNT_WIDTH, 32, width of the cycle and error counters
TIMEOUT, 1024, maximum cycles to wait for ack; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; ignored while busy
base_adr  in  ADDR_WIDTH  first word address; sampled on start
length  in  LEN_WIDTH  word count; 0 means done immediately with no bus traffic
mode  in  2  0 = address pattern, 1 = LFSR, 2 = fixed value, 3 = inverted address
seed  in  DATA_WIDTH  LFSR seed or fixed value; sampled on start
do_write  in  1  run the write pass
do_read  in  1  run the read/compare pass
busy  out  1  high from the cycle after start until done
done  out  1  sticky; cleared by the next accepted start
timeout  out  1  sticky; set when a transfer times out
error_count  out  CNT_WIDTH  count of mismatched words, saturating
first_err_adr  out  ADDR_WIDTH  address of the first mismatch
first_err_dat  out  DATA_WIDTH  read data of the first mismatch
cycle_count  out  CNT_WIDTH  clocks spent while busy, saturating
wb_adr  out  ADDR_WIDTH  Wishbone address
wb_dat_w  out  DATA_WIDTH  Wishbone write data
wb_dat_r  in  DATA_WIDTH  Wishbone read data
wb_sel  out  DATA_WIDTH/8  byte selects; always all ones
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  Wishbone write enable
wb_ack  in  1  Wishbone acknowledge

Behaviour:
- Reset: all outputs 0 and state IDLE. rst mid-run aborts at once and drops cyc/stb in the next cycle, even if a transfer is outstanding.
- FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FINISH.
- IDLE -> WR_REQ on start when do_write=1. Otherwise -> RD_REQ if do_read=1. Otherwise -> FINISH. length=0 always goes -> FINISH.
- On an accepted start:
  - latch base_adr, length and seed
  - clear error_count, first_err_*, cycle_count, done and timeout
  - load the pattern generator
- WR_REQ: cyc=stb=we=1. wb_adr = base + index; wb_dat_w = pattern(index). Hold until ack, then -> WR_GAP.
- WR_GAP: one idle cycle with cyc=stb=0. Then index+1, or at index=length-1 go to the read pass or FINISH.
- The read pass resets index to 0 and reloads the pattern generator from the latched seed.
- RD_REQ: same as WR_REQ with we=0. In the ack cycle, compare wb_dat_r with the expected pattern.
- On the first mismatch, capture the address and data into first_err_*. Every mismatch increments error_count, saturating at all ones.
- RD_GAP: as WR_GAP.
- FINISH: set done, drop busy next cycle, return to IDLE.
- Transfer latency: one request cycle minimum plus the ack wait, plus one gap cycle per word.
- Patterns per mode:
  - mode 0: pattern(index) = base + index, zero-extended or truncated to DATA_WIDTH
  - mode 3: bitwise inverse of mode 0
  - mode 2: pattern = seed for every word
  - mode 1: Galois LFSR over 32 bits, taps 0x80200003, advanced once per word, replicated across DATA_WIDTH. An all-zero seed is replaced with 1.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Timeout: a per-transfer counter starts at stb assertion. When it reaches TIMEOUT without ack: drop cyc/stb, set timeout, go to FINISH. error_count is left untouched.
- cycle_count increments every cycle busy=1.
- An ack arriving while stb=0 is ignored.

Decomposition:
- Shared package gram_bist_pkg holds:
  - mode encodings (MODE_ADDR, MODE_LFSR, MODE_FIXED, MODE_INV_ADDR)
  - FSM state enum
  - LFSR tap constant
- One sub-module, gram_bist_pattern: seed/load/advance in, current word out. The write and read passes use it identically, so regeneration matches by construction.

Test Plan:
- Wishbone RAM model with 1-cycle ack; base 0x4000000, length 16, mode 0, write+read -> 16 writes with data = address, error_count 0, done=1, cycle_count in 65..70.
- Same as above, with the model flipping bit 0 of the word at 0x4000005 -> error_count 1, first_err_adr 0x4000005, first_err_dat 0x4000004.
- Mode 1, seed 0, length 4, write-only -> wb_dat_w sequence matches the reference LFSR starting from seed 1; no read cycles issued.
- Model never acks, TIMEOUT 8 -> stb low 9 cycles after assertion, timeout=1, done=1.
- rst pulsed mid read pass -> next cycle cyc=stb=0 and all status outputs 0; a fresh start runs cleanly.
- length 0, or start while busy -> no bus activity and done set the next cycle; start while busy is ignored.
